// File: rtl/icdf_seg_addr_pipe.sv
// rtl/icdf_seg_addr_pipe.sv - inverse-CDF segment address translator, 2-stage valid/ready pipeline
module icdf_seg_addr_pipe #(
    parameter int LZ_W   = 6,
    parameter int SUB_W  = 1,
    parameter int MAX_LZ = 61,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LZ_W-1:0]   lz_count,
    input  logic [SUB_W-1:0]  sub_bits,
    input  logic              sign_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] seg_addr,
    output logic              sign_out,
    output logic              clamped,
    output logic [CNT_W-1:0]  clamp_cnt,
    input  logic              clamp_clr
);

    localparam logic [LZ_W-1:0]  MAX_LZ_V = LZ_W'(MAX_LZ);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic              s1_valid_q, s1_valid_d;
    logic [LZ_W-1:0]   s1_lz_q, s1_lz_d;
    logic [SUB_W-1:0]  s1_sub_q, s1_sub_d;
    logic              s1_clamp_q, s1_clamp_d;
    logic              s1_sign_q, s1_sign_d;

    logic              s2_valid_q, s2_valid_d;
    logic [ADDR_W-1:0] seg_addr_q, seg_addr_d;
    logic              sign_q, sign_d;
    logic              clamped_q, clamped_d;

    logic [CNT_W-1:0]  clamp_cnt_q, clamp_cnt_d;

    logic s1_load, s2_load, in_fire, in_over;

    // Bubble collapse: s1 can refill whenever it is empty, even while s2 stalls.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_fire  = in_valid && s1_load;
    assign in_over  = lz_count > MAX_LZ_V;
    assign in_ready = s1_load;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_lz_d     = s1_lz_q;
        s1_sub_d    = s1_sub_q;
        s1_clamp_d  = s1_clamp_q;
        s1_sign_d   = s1_sign_q;
        s2_valid_d  = s2_valid_q;
        seg_addr_d  = seg_addr_q;
        sign_d      = sign_q;
        clamped_d   = clamped_q;
        clamp_cnt_d = clamp_cnt_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_lz_d    = in_over ? MAX_LZ_V : lz_count;
            s1_sub_d   = in_over ? {SUB_W{1'b1}} : sub_bits;
            s1_clamp_d = in_over;
            s1_sign_d  = sign_in;
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load && s1_valid_q) begin
            seg_addr_d = {s1_lz_q, s1_sub_q};
            sign_d     = s1_sign_q;
            clamped_d  = s1_clamp_q;
        end

        if (clamp_clr) begin
            clamp_cnt_d = '0;
        end else if (in_fire && in_over && clamp_cnt_q != CNT_MAX) begin
            clamp_cnt_d = clamp_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_lz_q     <= '0;
            s1_sub_q    <= '0;
            s1_clamp_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            seg_addr_q  <= '0;
            sign_q      <= 1'b0;
            clamped_q   <= 1'b0;
            clamp_cnt_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lz_q     <= s1_lz_d;
            s1_sub_q    <= s1_sub_d;
            s1_clamp_q  <= s1_clamp_d;
            s1_sign_q   <= s1_sign_d;
            s2_valid_q  <= s2_valid_d;
            seg_addr_q  <= seg_addr_d;
            sign_q      <= sign_d;
            clamped_q   <= clamped_d;
            clamp_cnt_q <= clamp_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign seg_addr  = seg_addr_q;
    assign sign_out  = sign_q;
    assign clamped   = clamped_q;
    assign clamp_cnt = clamp_cnt_q;

endmodule

// File: tb/tb_icdf_seg_addr_pipe.sv
// tb/tb_icdf_seg_addr_pipe.sv - self-checking bench for icdf_seg_addr_pipe
module tb_icdf_seg_addr_pipe;

    localparam int LZ_W   = 6;
    localparam int SUB_W  = 1;
    localparam int MAX_LZ = 61;
    localparam int ADDR_W = 7;
    localparam int CNT_W  = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [LZ_W-1:0]   lz_count;
    logic [SUB_W-1:0]  sub_bits;
    logic              sign_in;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] seg_addr;
    logic              sign_out;
    logic              clamped;
    logic [CNT_W-1:0]  clamp_cnt;
    logic              clamp_clr;

    always #5 clk = ~clk;

    icdf_seg_addr_pipe #(
        .LZ_W(LZ_W), .SUB_W(SUB_W), .MAX_LZ(MAX_LZ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .lz_count(lz_count), .sub_bits(sub_bits), .sign_in(sign_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .seg_addr(seg_addr), .sign_out(sign_out), .clamped(clamped),
        .clamp_cnt(clamp_cnt), .clamp_clr(clamp_clr)
    );

    typedef struct {
        int   addr;
        logic sign;
        logic clmp;
        int   t;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    cnt = 0;
    logic  acc;
    logic  bp_mode = 1'b0;
    int    bp_idx = 0;
    logic  bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic int ref_addr(input int lz, input int sub);
        if (lz > MAX_LZ) return MAX_LZ * (2 ** SUB_W) + (2 ** SUB_W - 1);
        return lz * (2 ** SUB_W) + sub;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check at negedge against the reference queue, update the model at posedge.
    task automatic cycle();
        logic  exp_ir, exp_ov, pop;
        item_t it;
        pop = 1'b0;
        @(negedge clk);
        acc = 1'b0;
        if (!rst) begin
            exp_ir = (q.size() < 2) || out_ready;
            exp_ov = (q.size() > 0) && (q[0].t + 2 <= cyc);
            chk("in_ready", in_ready, exp_ir);
            chk("out_valid", out_valid, exp_ov);
            chk("clamp_cnt", clamp_cnt, cnt);
            if (exp_ov) begin
                chk("seg_addr", seg_addr, q[0].addr);
                chk("sign_out", sign_out, q[0].sign);
                chk("clamped", clamped, q[0].clmp);
            end
            acc = in_valid && exp_ir;
            pop = exp_ov && out_ready;
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            cnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (clamp_clr) cnt = 0;
            else if (acc && int'(lz_count) > MAX_LZ && cnt < CNT_SAT) cnt++;
            if (acc) begin
                it.addr = ref_addr(int'(lz_count), int'(sub_bits));
                it.sign = sign_in;
                it.clmp = int'(lz_count) > MAX_LZ;
                it.t    = cyc;
                q.push_back(it);
            end
        end
        cyc++;
        #1;
        if (bp_mode) begin
            out_ready = bp_pat[bp_idx % 6];
            bp_idx++;
        end
    endtask

    task automatic send(input int lz, input int sub, input logic sg);
        in_valid = 1'b1;
        lz_count = LZ_W'(lz);
        sub_bits = SUB_W'(sub);
        sign_in  = sg;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (acc) break;
        end
        chk("send_accept", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) cycle();
        chk("drain_empty", q.size() == 0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; lz_count = '0; sub_bits = '0;
        sign_in = 1'b0; out_ready = 1'b1; clamp_clr = 1'b0;
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_seg_addr", seg_addr, 0);
        chk("rst_sign_out", sign_out, 0);
        chk("rst_clamped", clamped, 0);
        chk("rst_out_valid", out_valid, 0);

        // Back-to-back stream with out_ready held high
        send(0, 0, 1'b0); send(0, 1, 1'b1); send(1, 0, 1'b0);
        send(1, 1, 1'b1); send(5, 0, 1'b0); send(5, 1, 1'b1);
        drain();

        // Clamp boundary
        send(61, 0, 1'b0); send(62, 0, 1'b1); send(63, 0, 1'b0);
        drain();
        chk("clamp_cnt_two", clamp_cnt, 2);

        // Backpressure with toggling out_ready
        bp_mode = 1'b1;
        for (int i = 0; i < 8; i++) send($urandom_range(0, 63), $urandom_range(0, 1), i[0]);
        for (int k = 0; k < 6; k++) cycle();
        bp_mode = 1'b0;
        drain();

        // Alternating sign with one-cycle input gaps
        for (int i = 0; i < 6; i++) begin
            send($urandom_range(0, 63), $urandom_range(0, 1), !i[0]);
            cycle();
        end
        drain();

        // Counter saturation and clear-over-increment priority
        clamp_clr = 1'b1; cycle(); clamp_clr = 1'b0;
        for (int i = 0; i < 20; i++) send(62 + (i % 2), i % 2, 1'b0);
        drain();
        chk("clamp_cnt_sat", clamp_cnt, CNT_SAT);
        clamp_clr = 1'b1;
        send(63, 0, 1'b1);
        clamp_clr = 1'b0;
        chk("clamp_clr_prio", clamp_cnt, 0);
        drain();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            lz_count  = LZ_W'($urandom_range(0, 63));
            sub_bits  = SUB_W'($urandom_range(0, 1));
            sign_in   = $urandom_range(0, 1);
            clamp_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end
        clamp_clr = 1'b0;
        drain();

        // Reset with both stages full and a clamped input pending
        out_ready = 1'b0;
        send(62, 0, 1'b1); send(63, 1, 1'b0);
        in_valid = 1'b1; lz_count = LZ_W'(63); rst = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_clamp_cnt", clamp_cnt, 0);
        out_ready = 1'b1;
        send(3, 1, 1'b1);
        cycle();
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_seg_addr", seg_addr, 7);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icdf_seg_addr_pipe.md
Name: icdf_seg_addr_pipe

Overview:
Parametrised segment-address translator for the Gaussian noise generator's inverse-CDF path. It takes the leading-zero count of the uniform sample and the SUB_W bits that follow the leading one, and forms the coefficient-ROM segment address. Out-of-range counts are clamped to the last segment, and clamp events are counted for statistics. It has a 2-stage registered pipeline with valid/ready backpressure and a sign sideband, and sits between the LZD and the coefficient ROM / polynomial evaluator.

Parameters:
LZ_W, 6, width of leading-zero count input
SUB_W, 1, number of sub-segment bits following the leading one (1..4)
MAX_LZ, 61, largest leading-zero count with its own segment; must be less than 2^LZ_W
ADDR_W, 7, segment address width; must equal LZ_W+SUB_W
CNT_W, 16, width of saturating clamp counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input sample valid
in_ready  output  1  block can accept input this cycle
lz_count  input  LZ_W  leading-zero count from LZD
sub_bits  input  SUB_W  bits below the leading one, MSB first
sign_in  input  1  sample sign sideband, passed through unchanged
out_valid  output  1  seg_addr/sign_out valid
out_ready  input  1  downstream accepts output
seg_addr  output  ADDR_W  ROM segment address
sign_out  output  1  delayed sign_in
clamped  output  1  this output was clamped (lz_count > MAX_LZ)
clamp_cnt  output  CNT_W  number of clamped samples accepted since reset, saturating
clamp_clr  input  1  synchronous clear of clamp_cnt

Behaviour:
- Transfer: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Stage 1 (s1) computes the following values:
  - lz_eff = min(lz_count, MAX_LZ)
  - sub_eff = sub_bits, or all-ones if lz_count > MAX_LZ
  - clamped flag
  - sign
- Stage 2 (s2) registers seg_addr = lz_eff * 2^SUB_W + sub_eff, i.e. the concatenation {lz_eff, sub_eff}, together with sign and clamped.
- Outputs are driven directly from s2 registers; there is no combinational path from inputs to outputs.
- Load conditions:
  - s2_load = !s2_valid || out_ready
  - s1_load = !s1_valid || s2_load
  - in_ready = s1_load (combinational from out_ready and the valid regs)
- Latency: 2 cycles from accepted input to out_valid while out_ready stays high. Throughput is 1 sample/cycle.
- Stall: when out_ready=0 and both stages are full, in_ready=0. s1, s2 and the outputs hold stable. No sample is dropped or duplicated.
- Bubble collapse: if s2 is full and stalled but s1 is empty, the block accepts one more sample into s1.
- When s1 is empty and s2_load is true, s2_valid clears at the next edge.
- Data registers are loaded only on their stage load enable. Their values while the valid bit is low are don't-care, but seg_addr/sign_out/clamped reset to 0.
- clamp_cnt:
  - Increments by 1 on each accepted input with lz_count > MAX_LZ (counted at input acceptance).
  - Saturates at 2^CNT_W-1.
  - clamp_clr forces it to 0 and takes priority over a same-cycle increment.
- Reset (rst=1 at a clock edge) sets s1_valid, s2_valid, out_valid, seg_addr, sign_out, clamped and clamp_cnt to 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight samples. An input presented during the reset cycle is not accepted and not counted.
- Boundaries:
  - lz_count == MAX_LZ is not clamped.
  - lz_count = 2^LZ_W-1 (all-zero sample) is clamped.
  - With MAX_LZ=61 and SUB_W=1, the clamped address is 61*2+1 = 123.

Test Plan:
1. Reset then stream, out_ready=1: rst high 2 cycles, then send (lz,sub) = (0,0),(0,1),(1,0),(1,1),(5,0),(5,1) back-to-back → seg_addr 0,1,2,3,10,11, each 2 cycles after acceptance; out_valid continuous; clamped=0.
2. Clamp boundary: lz=61,sub=0 → addr 122, clamped=0. lz=62,sub=0 → 123, clamped=1. lz=63,sub=0 → 123, clamped=1. clamp_cnt ends at 2.
3. Backpressure: stream 8 samples with out_ready toggling 1,0,0,1,0,1,... → in_ready drops when both stages are full; output sequence equals input order exactly; seg_addr/sign_out stable while out_valid && !out_ready.
4. Sign and bubble: sign_in alternating 1,0 with in_valid gaps of 1 cycle → sign_out matches per sample; out_valid shows matching gaps; no spurious output.
5. Counter: CNT_W=4, send 20 clamped samples → clamp_cnt saturates at 15. Assert clamp_clr on the same cycle as a clamped accept → clamp_cnt=0.
6. Reset mid-stream: rst asserted with both stages full and out_ready=0 → next cycle out_valid=0, clamp_cnt=0, in_ready=1; the first post-reset sample (lz=3,sub=1) gives addr 7 after 2 cycles.
